// File: rtl/bounding_box.sv
// bounding_box: serial-in triangle bounding box.
//
// A 144-bit frame is shifted in LSB first, one bit per clk while en=1.
// The frame carries three vertices as unsigned 10.6 fixed point:
//   v0x=[15:0] v1x=[31:16] v2x=[47:32] v0y=[63:48] v1y=[79:64] v2y=[95:80]
// Bits [143:96] are reserved and ignored by the box logic. One clk after
// the 144th accepted bit, the min/max of each axis are registered and
// bb_valid pulses for one cycle. Box outputs hold until the next frame.
//
// Optional feature (macro BOUNDING_BOX_CLAMP_EN): clamp x outputs to
// (SCREEN_W-1)<<6 and y outputs to (SCREEN_H-1)<<6 after min/max.
//
// Ports:
//   clk      - clock, rising edge
//   rst_n    - asynchronous active-low reset
//   en       - accept the bit on `in` this cycle
//   in       - serial frame data, LSB first
//   frame_q  - shift register contents
//   xmin/xmax/ymin/ymax - registered bounding box (10.6 unsigned)
//   bb_valid - one-cycle pulse when the box updates

// Per-axis min/max of three vertices, with optional upper clamp.
module bounding_box_lane #(
    parameter int                VEC_W    = 16,
    parameter bit                CLAMP_EN = 1'b0,
    parameter logic [VEC_W-1:0]  LIMIT    = '1
) (
    input  logic [2:0][VEC_W-1:0] v,
    output logic [VEC_W-1:0]      lo,
    output logic [VEC_W-1:0]      hi
);
    logic [VEC_W-1:0] mn, mx;

    always_comb begin
        mn = v[0];
        mx = v[0];
        for (int k = 1; k < 3; k++) begin
            if (v[k] < mn) mn = v[k];
            if (v[k] > mx) mx = v[k];
        end
        lo = (CLAMP_EN && (mn > LIMIT)) ? LIMIT : mn;
        hi = (CLAMP_EN && (mx > LIMIT)) ? LIMIT : mx;
    end
endmodule

module bounding_box #(
    parameter int SCREEN_W = 640,
    parameter int SCREEN_H = 480
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         in,
    output logic [143:0] frame_q,
    output logic [15:0]  xmin,
    output logic [15:0]  xmax,
    output logic [15:0]  ymin,
    output logic [15:0]  ymax,
    output logic         bb_valid
);
    localparam int FRAME_W   = 144;
    localparam int VEC_W     = 16;
    localparam int NUM_LANES = 2;   // lane 0 = x, lane 1 = y
    localparam int STAGES    = 1;

`ifdef BOUNDING_BOX_CLAMP_EN
    localparam bit CLAMP_EN = 1'b1;
`else
    localparam bit CLAMP_EN = 1'b0;
`endif

    // Per-lane clamp limit in 10.6 format; only consulted when CLAMP_EN.
    localparam logic [NUM_LANES-1:0][VEC_W-1:0] LIMIT = {
        VEC_W'((SCREEN_H - 1) << 6),
        VEC_W'((SCREEN_W - 1) << 6)
    };

    logic [7:0]                         cnt;
    logic                               frame_done;
    // vld_pipe[0]: frame just completed, load box next edge
    // vld_pipe[1]: box registers hold the new result
    logic [STAGES:0]                    vld_pipe;
    logic [NUM_LANES-1:0][2:0][VEC_W-1:0] verts;
    logic [NUM_LANES-1:0][VEC_W-1:0]    lo_c, hi_c, lo_q, hi_q;

    assign frame_done = en && (cnt == 8'(FRAME_W - 1));
    assign verts      = frame_q[NUM_LANES*3*VEC_W-1:0];

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        bounding_box_lane #(
            .VEC_W    (VEC_W),
            .CLAMP_EN (CLAMP_EN),
            .LIMIT    (LIMIT[g])
        ) u_lane (
            .v  (verts[g]),
            .lo (lo_c[g]),
            .hi (hi_c[g])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_q  <= '0;
            cnt      <= '0;
            vld_pipe <= '0;
            lo_q     <= '0;
            hi_q     <= '0;
        end else begin
            if (en) begin
                frame_q <= {in, frame_q[FRAME_W-1:1]};
                cnt     <= frame_done ? 8'd0 : cnt + 8'd1;
            end
            vld_pipe <= {vld_pipe[STAGES-1:0], frame_done};
            // frame_q still holds the completed frame here even if a new
            // frame's first bit is shifting in on this same edge.
            if (vld_pipe[0]) begin
                lo_q <= lo_c;
                hi_q <= hi_c;
            end
        end
    end

    assign xmin     = lo_q[0];
    assign xmax     = hi_q[0];
    assign ymin     = lo_q[1];
    assign ymax     = hi_q[1];
    assign bb_valid = vld_pipe[STAGES];
endmodule

// File: tb/tb_bounding_box.sv
// tb_bounding_box: directed vectors for bounding_box with hand-computed
// boxes. Expected boxes are packed {ymax, ymin, xmax, xmin}.
module tb_bounding_box;
    logic         clk = 1'b0;
    logic         rst_n;
    logic         en;
    logic         in;
    logic [143:0] frame_q;
    logic [15:0]  xmin, xmax, ymin, ymax;
    logic         bb_valid;

    int total = 0;
    int bad   = 0;
    int pulses = 0;

    logic [143:0] fr [0:1];
    logic [63:0]  ex [0:1];
    logic [143:0] last_frame;
    logic [63:0]  last_box;

    bounding_box u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .in       (in),
        .frame_q  (frame_q),
        .xmin     (xmin),
        .xmax     (xmax),
        .ymin     (ymin),
        .ymax     (ymax),
        .bb_valid (bb_valid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (bb_valid) pulses++;

    task automatic chk(input string tag, input logic [143:0] got, input logic [143:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", tag, got, want);
        end
    endtask

    function automatic logic [143:0] mk(input logic [15:0] v0x, v1x, v2x, v0y, v1y, v2y,
                                        input logic [47:0] rsv);
        return {rsv, v2y, v1y, v0y, v2x, v1x, v0x};
    endfunction

    // Stream nfr frames from fr[] back to back; optionally drop en for
    // gap_len cycles just before frame-0 bit gap_at.
    task automatic run(input int nfr, input int gap_at, input int gap_len);
        int n;
        n = nfr * 144 + 2;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (i >= 144 && (i - 144) % 144 == 0)
                chk("vld_early", 144'(bb_valid), 144'(0));
            if (i >= 145 && (i - 145) % 144 == 0) begin
                chk("vld", 144'(bb_valid), 144'(1));
                chk("box", 144'({ymax, ymin, xmax, xmin}), 144'(ex[(i - 145) / 144]));
            end
            if (i == gap_at) begin
                en = 1'b0;
                for (int g = 0; g < gap_len; g++) begin
                    @(negedge clk);
                    chk("gap_vld", 144'(bb_valid), 144'(0));
                    chk("gap_fq", frame_q, (last_frame >> gap_at) | (fr[0] << (144 - gap_at)));
                    chk("gap_hold", 144'({ymax, ymin, xmax, xmin}), 144'(last_box));
                end
            end
            if (i < nfr * 144) begin
                en = 1'b1;
                in = fr[i / 144][i % 144];
            end else begin
                en = 1'b0;
            end
        end
        chk("frame_q", frame_q, fr[nfr - 1]);
        last_frame = fr[nfr - 1];
        last_box   = ex[nfr - 1];
    endtask

    initial begin
        logic [143:0] fa;
        rst_n = 1'b0;
        en    = 1'b0;
        in    = 1'b0;
        last_frame = '0;
        last_box   = '0;
        repeat (2) @(negedge clk);
        chk("rst_box", 144'({ymax, ymin, xmax, xmin}), 144'(0));
        chk("rst_vld", 144'(bb_valid), 144'(0));
        chk("rst_fq", frame_q, 144'(0));
        rst_n = 1'b1;

        // Mixed extremes
        fa = mk(16'hFFC0, 16'h003F, 16'hAAAA, 16'h003F, 16'hFFC0, 16'h5555, 48'h0);
        fr[0] = fa;
`ifdef BOUNDING_BOX_CLAMP_EN
        ex[0] = {16'h77C0, 16'h003F, 16'h9FC0, 16'h003F};
`else
        ex[0] = {16'hFFC0, 16'h003F, 16'hFFC0, 16'h003F};
`endif
        run(1, -1, 0);

        // All vertices equal; reserved bits must not matter
        fr[0] = mk(16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 48'hDEAD_BEEF_1234);
        ex[0] = {16'h0100, 16'h0100, 16'h0100, 16'h0100};
        run(1, -1, 0);

        // First frame again with a 10-cycle en gap at bit 70
        fr[0] = fa;
`ifdef BOUNDING_BOX_CLAMP_EN
        ex[0] = {16'h77C0, 16'h003F, 16'h9FC0, 16'h003F};
`else
        ex[0] = {16'hFFC0, 16'h003F, 16'hFFC0, 16'h003F};
`endif
        run(1, 70, 10);

        // Reset after 50 bits of a frame
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            en = 1'b1;
            in = fa[i];
        end
        @(negedge clk);
        en    = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_box", 144'({ymax, ymin, xmax, xmin}), 144'(0));
        chk("mid_rst_fq", frame_q, 144'(0));
        chk("mid_rst_vld", 144'(bb_valid), 144'(0));
        @(negedge clk);
        chk("mid_rst_hold", 144'({ymax, ymin, xmax, xmin}), 144'(0));
        rst_n = 1'b1;
        last_frame = '0;
        last_box   = '0;
        fr[0] = mk(16'h1234, 16'h0567, 16'h0890, 16'h2000, 16'h1FFF, 16'h2001, 48'h0);
        ex[0] = {16'h2001, 16'h1FFF, 16'h1234, 16'h0567};
        run(1, -1, 0);

        // Two frames back to back, no gap
        fr[0] = mk(16'h0040, 16'h0100, 16'h0200, 16'h0300, 16'h0040, 16'h0080, 48'h0);
        ex[0] = {16'h0300, 16'h0040, 16'h0200, 16'h0040};
        fr[1] = mk(16'h0080, 16'h0080, 16'h0080, 16'hA000, 16'h0001, 16'h7FFF, 48'h0);
`ifdef BOUNDING_BOX_CLAMP_EN
        ex[1] = {16'h77C0, 16'h0001, 16'h0080, 16'h0080};
`else
        ex[1] = {16'hA000, 16'h0001, 16'h0080, 16'h0080};
`endif
        run(2, -1, 0);

        repeat (3) @(negedge clk);
        chk("pulses", 144'(pulses), 144'(6));
        chk("idle_hold", 144'({ymax, ymin, xmax, xmin}), 144'(ex[1]));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/bounding_box.md
BOUNDING_BOX -- requirements
Module: bounding_box

Interface
- REQ-001: Parameter SCREEN_W, default 640, sets the screen width in integer pixels; it is used only when BOUNDING_BOX_CLAMP_EN is defined.
- REQ-002: Parameter SCREEN_H, default 480, sets the screen height in integer pixels; it is used only when BOUNDING_BOX_CLAMP_EN is defined.
- REQ-003: clk, input, 1 bit: the single clock; all state changes on its rising edge.
- REQ-004: rst_n, input, 1 bit: asynchronous, active-low reset.
- REQ-005: en, input, 1 bit: serial-bit enable; the bit on `in` is accepted on each rising clk while en=1.
- REQ-006: in, input, 1 bit: serial data, LSB of the 144-bit frame first.
- REQ-007: frame_q, output, 144 bits: the shift-register contents.
- REQ-008: xmin, xmax, ymin, ymax, outputs, 16 bits each: registered bounding box, unsigned fixed point 10.6 (bits [15:6] integer, [5:0] fraction).
- REQ-009: bb_valid, output, 1 bit: one-cycle pulse when xmin/xmax/ymin/ymax update.

Function
- REQ-010: Frame layout: v0x=[15:0], v1x=[31:16], v2x=[47:32], v0y=[63:48], v1y=[79:64], v2y=[95:80]; bits [143:96] are reserved and ignored by the box logic.
- REQ-011: Shifting: on each clk with en=1, frame_q <= {in, frame_q[143:1]}, so after 144 accepted bits, frame bit i sits at frame_q[i].
- REQ-012: With en=0, frame_q and the bit counter hold.
- REQ-013: An 8-bit counter counts accepted bits 0..143 and wraps to 0 on the edge accepting the 144th bit; the next bit starts a new frame with no gap.
- REQ-014: Frame-complete condition: en=1 and counter=143 on a rising edge.
- REQ-015: On the edge after frame-complete, outputs load from frame_q: xmin=min(v0x,v1x,v2x), xmax=max(v0x,v1x,v2x), ymin=min(v0y,v1y,v2y), ymax=max(v0y,v1y,v2y).
- REQ-016: bb_valid is 1 for exactly that one cycle.
- REQ-017: Comparisons are 16-bit unsigned; equal values yield that value; no rounding or width growth.
- REQ-018: Latency is one clk from the 144th accepted bit to valid outputs.
- REQ-019: Box outputs hold their value until the next frame completes, regardless of en.
- REQ-020: If en drops mid-frame, the frame resumes when en returns; there is no timeout.
- REQ-021: A frame completing on the same edge as the previous bb_valid pulse still produces its own pulse one edge later.

Reset
- REQ-022: rst_n=0 asynchronously clears frame_q, the counter, all four box outputs and bb_valid to 0.
- REQ-023: Reset mid-frame discards partial bits; the next accepted bit is frame bit 0.
- REQ-024: Release of rst_n is used synchronously to clk.

Configuration
- REQ-025: Without BOUNDING_BOX_CLAMP_EN, outputs are the raw min/max of REQ-015.
- REQ-026: With BOUNDING_BOX_CLAMP_EN, each x output is clamped to at most (SCREEN_W-1)<<6 and each y output to at most (SCREEN_H-1)<<6, applied after min/max, same latency.

Verification
- REQ-027: Send frame v0x=FFC0h, v1x=003Fh, v2x=AAAAh, v0y=003Fh, v1y=FFC0h, v2y=5555h, rest 0, en=1, macro off -> one cycle after bit 144: xmin=003Fh, xmax=FFC0h, ymin=003Fh, ymax=FFC0h, bb_valid pulses once.
- REQ-028: Same frame with macro on, default parameters -> xmax=9FC0h, ymax=77C0h, xmin=003Fh, ymin=003Fh.
- REQ-029: All vertices 0100h (4.0) -> all four outputs 0100h.
- REQ-030: en toggled low for 10 cycles at bit 70 -> same result as the uninterrupted frame, delayed 10 cycles.
- REQ-031: rst_n pulsed low at bit 50, then a full frame sent -> all outputs read 0 during reset; afterwards the correct box from the new frame only.
- REQ-032: Two frames sent back-to-back (v0x=0040h, 0080h, then other values) -> two bb_valid pulses 144 cycles apart, each with the matching box.
